// File: rtl/bus_arbiter_split.sv
// Two-master bus arbiter with single-outstanding split support.
// A parked master is resumed by split_done; an optional timeout releases it without priority.
module bus_arbiter_split #(
  parameter int ROUND_ROBIN   = 1,
  parameter int SPLIT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic mbreq1,
  input  logic mbreq2,
  input  logic split_req,
  input  logic split_done,
  output logic mbgrant1,
  output logic mbgrant2,
  output logic msplit1,
  output logic msplit2,
  output logic msel,
  output logic bus_busy,
  output logic split_err,
  output logic timeout_err
);

  localparam int CW = (SPLIT_TIMEOUT > 0) ? $clog2(SPLIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((SPLIT_TIMEOUT > 0) ? SPLIT_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_e;

  state_e        state_q, state_d;
  logic          parked1_q, parked1_d, parked2_q, parked2_d;
  logic          pend1_q, pend1_d, pend2_q, pend2_d;
  logic          last_q, last_d;   // 0 = master 1 owned the bus last, 1 = master 2
  logic          msel_q, msel_d;
  logic          split_err_q, split_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          elig1, elig2, any_parked, pick2;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    parked1_d     = parked1_q;
    parked2_d     = parked2_q;
    pend1_d       = pend1_q;
    pend2_d       = pend2_q;
    last_d        = last_q;
    msel_d        = msel_q;
    cnt_d         = cnt_q;
    split_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    any_parked = parked1_q | parked2_q;
    elig1      = mbreq1 & ~parked1_q;
    elig2      = mbreq2 & ~parked2_q;

    if (pend1_q && elig1)      pick2 = 1'b0;
    else if (pend2_q && elig2) pick2 = 1'b1;
    else if (elig1 && elig2)   pick2 = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
    else                       pick2 = elig2;

    unique case (state_q)
      IDLE: begin
        if (!mbreq1) pend1_d = 1'b0;
        if (!mbreq2) pend2_d = 1'b0;
        if (elig1 || elig2) begin
          state_d = pick2 ? GNT2 : GNT1;
          last_d  = pick2;
          msel_d  = pick2;
          if (pick2) pend2_d = 1'b0;
          else       pend1_d = 1'b0;
        end
      end
      GNT1: begin
        if (split_req && !any_parked) begin
          state_d   = IDLE;
          parked1_d = 1'b1;
          cnt_d     = '0;
        end else begin
          split_err_d = split_req;
          if (!mbreq1) state_d = IDLE;
        end
      end
      GNT2: begin
        if (split_req && !any_parked) begin
          state_d   = IDLE;
          parked2_d = 1'b1;
          cnt_d     = '0;
        end else begin
          split_err_d = split_req;
          if (!mbreq2) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Resume and timeout only apply to an already parked master.
    if (any_parked) begin
      if (split_done) begin
        parked1_d = 1'b0;
        parked2_d = 1'b0;
        pend1_d   = pend1_d | parked1_q;
        pend2_d   = pend2_d | parked2_q;
        cnt_d     = '0;
      end else if (SPLIT_TIMEOUT > 0) begin
        if (cnt_q == CNT_LAST) begin
          parked1_d     = 1'b0;
          parked2_d     = 1'b0;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      parked1_q     <= 1'b0;
      parked2_q     <= 1'b0;
      pend1_q       <= 1'b0;
      pend2_q       <= 1'b0;
      last_q        <= 1'b1;
      msel_q        <= 1'b0;
      split_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      parked1_q     <= parked1_d;
      parked2_q     <= parked2_d;
      pend1_q       <= pend1_d;
      pend2_q       <= pend2_d;
      last_q        <= last_d;
      msel_q        <= msel_d;
      split_err_q   <= split_err_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign mbgrant1    = (state_q == GNT1);
  assign mbgrant2    = (state_q == GNT2);
  assign bus_busy    = (state_q != IDLE);
  assign msplit1     = parked1_q;
  assign msplit2     = parked2_q;
  assign msel        = msel_q;
  assign split_err   = split_err_q;
  assign timeout_err = timeout_err_q;

endmodule
